// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: program-ROM port, datapath status inputs, decoder-facing IR fields.
// Latency: none, wires only.
// Backpressure: stall from the datapath holds the sequencer in EXEC.
interface fetch_sequencer_if #(
  parameter int AW = 10,
  parameter int IW = 18
);
  logic [AW-1:0] pm_addr;
  logic          pm_rd;
  logic [IW-1:0] pm_data;
  logic          stall;
  logic          w_zero;
  logic          w_sign;
  logic          carry;
  logic [7:0]    opcode;
  logic [4:0]    ri;
  logic [4:0]    rj;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic          stack_err;

  // Sequencer side
  modport master (
    output pm_addr, pm_rd, opcode, ri, rj, ir_valid, pc, stack_err,
    input  pm_data, stall, w_zero, w_sign, carry
  );

  // ROM / decoder / datapath side
  modport slave (
    input  pm_addr, pm_rd, opcode, ri, rj, ir_valid, pc, stack_err,
    output pm_data, stall, w_zero, w_sign, carry
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, ROM read, IR latch, jump/branch and BSR/RET return stack.
// Latency: 3 cycles per instruction (FETCH, LOAD, EXEC); ir_valid is high for the whole EXEC phase.
// Backpressure: stall holds EXEC with IR, PC and stack frozen; FETCH_STACK_ERR_EN selects trap-on-stack-error.
module fetch_sequencer #(
  parameter int AW          = 10,
  parameter int IW          = 18,
  parameter int STACK_DEPTH = 4,
  parameter int TRAP_VECTOR = 0
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IXW = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  // Depth must be a power of two so the stack index wraps naturally; trap PC must fit.
  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0 ||
      TRAP_VECTOR < 0 || TRAP_VECTOR >= (1 << AW)) begin : g_param_check
    $error("fetch_sequencer: STACK_DEPTH must be a power of two >= 2 and TRAP_VECTOR must fit in AW bits");
  end

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           commit;
  logic [IW-1:0]  ir_q;
  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q;
  logic [AW-1:0]  stk_q [STACK_DEPTH];
  logic           push, pop, push_wrap;
  logic [7:0]     op;
  logic [AW-1:0]  target, pc_inc;
  logic [IXW-1:0] push_idx, pop_idx;

`ifdef FETCH_STACK_ERR_EN
  localparam logic [AW-1:0] TRAP_PC = AW'(TRAP_VECTOR);
  logic err_q, err_set;
`endif

  assign op       = ir_q[IW-1 -: 8];
  assign target   = AW'({ir_q[9:5], ir_q[4:0]});
  assign pc_inc   = pc_q + AW'(1);
  assign push_idx = IXW'(sp_q);
  assign pop_idx  = IXW'(sp_q - SPW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Phase sequencing; EXEC only retires when the datapath is not stalling
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_EXEC;
      S_EXEC: begin
        if (!bus.stall) begin
          commit  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Next-PC and stack action from the IR; flags only matter on the committing cycle
  always_comb begin
    pc_d      = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    push_wrap = 1'b0;
`ifdef FETCH_STACK_ERR_EN
    err_set   = 1'b0;
`endif
    if (op[7:3] == 5'b00100) begin
      pc_d = target;
    end else if (op[7:3] == 5'b00101) begin
      if (bus.w_zero) pc_d = target;
    end else if (op[7:3] == 5'b00110) begin
      if (!bus.w_sign) pc_d = target;
    end else if (op[7:3] == 5'b00111) begin
      if (bus.carry) pc_d = target;
    end else if (op[7:2] == 6'b000111) begin
`ifdef FETCH_STACK_ERR_EN
      if (sp_q == SP_FULL) begin
        err_set = 1'b1;
        pc_d    = TRAP_PC;
      end else begin
        push = 1'b1;
        pc_d = pc_q + target;
      end
`else
      pc_d = pc_q + target;
      if (sp_q == SP_FULL) push_wrap = 1'b1;
      else                 push      = 1'b1;
`endif
    end else if (op == 8'h41) begin
`ifdef FETCH_STACK_ERR_EN
      if (sp_q == '0) begin
        err_set = 1'b1;
        pc_d    = TRAP_PC;
      end else begin
        pop  = 1'b1;
        pc_d = stk_q[pop_idx];
      end
`else
      if (sp_q == '0) begin
        pc_d = stk_q[STACK_DEPTH-1];
      end else begin
        pop  = 1'b1;
        pc_d = stk_q[pop_idx];
      end
`endif
    end
  end

  // Instruction register: captures ROM data one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (reset)                 ir_q <= '0;
    else if (state_q == S_LOAD) ir_q <= bus.pm_data;
  end

  // PC and stack pointer advance only when EXEC retires
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      sp_q <= '0;
    end else if (commit) begin
      pc_q <= pc_d;
      if (push)     sp_q <= sp_q + SPW'(1);
      else if (pop) sp_q <= sp_q - SPW'(1);
    end
  end

  // Stack storage; a full circular stack slides down so the newest entry stays on top
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      if (push) begin
        stk_q[push_idx] <= pc_inc;
      end else if (push_wrap) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
        stk_q[STACK_DEPTH-1] <= pc_inc;
      end
    end
  end

`ifdef FETCH_STACK_ERR_EN
  // Sticky stack error, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)                  err_q <= 1'b0;
    else if (commit && err_set) err_q <= 1'b1;
  end
  assign bus.stack_err = err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  // Strobes are forced low while reset is held so nothing leaks out mid-reset
  assign bus.pm_rd    = (state_q == S_FETCH) && !reset;
  assign bus.pm_addr  = pc_q;
  assign bus.ir_valid = (state_q == S_EXEC) && !reset;
  assign bus.opcode   = op;
  assign bus.ri       = ir_q[9:5];
  assign bus.rj       = ir_q[4:0];
  assign bus.pc       = pc_q;

endmodule
